// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the two-master arbiter slice.
//   - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   - Master index constants M0 (Ibex core) and M1 (DMA/debug)
//   - Default address/data widths
package ahb_pkg;

  localparam int unsigned AHB_AW = 32;
  localparam int unsigned AHB_DW = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/ahb_addr_capture.sv
// Per-master address-phase capture register.
// Holds a master's accepted-but-not-issued address phase and its pending
// flag, and presents either the captured phase (pending) or the live inputs.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load                      capture the live address phase, set pend
//   clear                     captured phase has been issued, drop pend
//   live_addr/trans/write/size  master's live address phase
//   pend                      a captured transfer is waiting
//   src_addr/trans/write/size address-phase source for the bus mux
module ahb_addr_capture
  import ahb_pkg::*;
#(
  parameter int unsigned AW = AHB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [AW-1:0] live_addr,
  input  logic [1:0]    live_trans,
  input  logic          live_write,
  input  logic [2:0]    live_size,
  output logic          pend,
  output logic [AW-1:0] src_addr,
  output logic [1:0]    src_trans,
  output logic          src_write,
  output logic [2:0]    src_size
);

  logic [AW-1:0] cap_addr;
  logic [1:0]    cap_trans;
  logic          cap_write;
  logic [2:0]    cap_size;

  // load only fires while the master sees HREADY high, which never happens
  // with pend set, so load and clear are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (load) begin
      pend <= 1'b1;
    end else if (clear) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      cap_addr  <= live_addr;
      cap_trans <= live_trans;
      cap_write <= live_write;
      cap_size  <= live_size;
    end
  end

  always_comb begin
    if (pend) begin
      src_addr  = cap_addr;
      src_trans = cap_trans;
      src_write = cap_write;
      src_size  = cap_size;
    end else begin
      src_addr  = live_addr;
      src_trans = live_trans;
      src_write = live_write;
      src_size  = live_size;
    end
  end

  single_capture: assert property (@(posedge clk) disable iff (rst) !(load && pend));

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter sharing the system bus between M0 (Ibex) and
// M1 (DMA/debug). Uncontended transfers pass straight through; a losing
// master's accepted address phase is captured and the master is stalled via
// its own HREADY until that transfer is issued and completed.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration (last_gnt);
// otherwise fixed priority with M0 highest.
// Ports:
//   HCLK, HRESET                 clock, synchronous active-high reset
//   H*_M0 / H*_M1 (in)           master address phase and write data
//   HREADY_M0/M1, HRDATA_M0/M1   per-master ready and read data
//   HADDR, HTRANS, HWRITE, HSIZE bus address phase
//   HWDATA                       bus write data (data-phase owner)
//   HREADY, HRDATA               bus ready and read data from the slave mux
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned AW = AHB_AW,
  parameter int unsigned DW = AHB_DW
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [AW-1:0] HADDR_M0,
  input  logic [1:0]    HTRANS_M0,
  input  logic          HWRITE_M0,
  input  logic [2:0]    HSIZE_M0,
  input  logic [DW-1:0] HWDATA_M0,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic [DW-1:0] HWDATA_M1,
  output logic          HREADY_M0,
  output logic          HREADY_M1,
  output logic [DW-1:0] HRDATA_M0,
  output logic [DW-1:0] HRDATA_M1,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA
);

  logic          pend_m0, pend_m1;
  logic [AW-1:0] src_addr_m0, src_addr_m1;
  logic [1:0]    src_trans_m0, src_trans_m1;
  logic          src_write_m0, src_write_m1;
  logic [2:0]    src_size_m0, src_size_m1;
  logic          req_m0, req_m1;
  logic          gnt;
  logic          issue;
  logic          dp_valid, dp_owner;
  logic          load_m0, load_m1, clear_m0, clear_m1;

  assign req_m0 = pend_m0 | HTRANS_M0[1];
  assign req_m1 = pend_m1 | HTRANS_M1[1];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;

  always_comb begin
    gnt = last_gnt;
    if (req_m0 && req_m1) begin
      gnt = ~last_gnt;
    end else if (req_m0) begin
      gnt = M0;
    end else if (req_m1) begin
      gnt = M1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_gnt <= M1;
    end else if (issue) begin
      last_gnt <= gnt;
    end
  end
`else
  always_comb begin
    gnt = M0;
    if (!req_m0 && req_m1) begin
      gnt = M1;
    end
  end
`endif

  always_comb begin
    if (gnt == M1) begin
      HADDR  = src_addr_m1;
      HTRANS = src_trans_m1;
      HWRITE = src_write_m1;
      HSIZE  = src_size_m1;
    end else begin
      HADDR  = src_addr_m0;
      HTRANS = src_trans_m0;
      HWRITE = src_write_m0;
      HSIZE  = src_size_m0;
    end
    if (!(req_m0 || req_m1)) begin
      HTRANS = HTRANS_IDLE;
    end
  end

  assign issue = HREADY & HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_owner <= M0;
    end else if (HREADY) begin
      dp_valid <= HTRANS[1];
      dp_owner <= gnt;
    end
  end

  assign HREADY_M0 = (dp_valid && dp_owner == M0) ? HREADY : ~pend_m0;
  assign HREADY_M1 = (dp_valid && dp_owner == M1) ? HREADY : ~pend_m1;

  // Capture an accepted transfer unless it went out live on this same edge;
  // a pending master is always driven from its capture, never live.
  assign load_m0  = HREADY_M0 & HTRANS_M0[1] & ~(issue & (gnt == M0) & ~pend_m0);
  assign load_m1  = HREADY_M1 & HTRANS_M1[1] & ~(issue & (gnt == M1) & ~pend_m1);
  assign clear_m0 = issue & (gnt == M0) & pend_m0;
  assign clear_m1 = issue & (gnt == M1) & pend_m1;

  ahb_addr_capture #(.AW(AW)) u_cap_m0 (
    .clk        (HCLK),
    .rst        (HRESET),
    .load       (load_m0),
    .clear      (clear_m0),
    .live_addr  (HADDR_M0),
    .live_trans (HTRANS_M0),
    .live_write (HWRITE_M0),
    .live_size  (HSIZE_M0),
    .pend       (pend_m0),
    .src_addr   (src_addr_m0),
    .src_trans  (src_trans_m0),
    .src_write  (src_write_m0),
    .src_size   (src_size_m0)
  );

  ahb_addr_capture #(.AW(AW)) u_cap_m1 (
    .clk        (HCLK),
    .rst        (HRESET),
    .load       (load_m1),
    .clear      (clear_m1),
    .live_addr  (HADDR_M1),
    .live_trans (HTRANS_M1),
    .live_write (HWRITE_M1),
    .live_size  (HSIZE_M1),
    .pend       (pend_m1),
    .src_addr   (src_addr_m1),
    .src_trans  (src_trans_m1),
    .src_write  (src_write_m1),
    .src_size   (src_size_m1)
  );

  assign HWDATA    = (dp_owner == M1) ? HWDATA_M1 : HWDATA_M0;
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;

  pend_not_owner_m0: assert property (@(posedge HCLK) disable iff (HRESET)
    !(pend_m0 && dp_valid && dp_owner == M0));
  pend_not_owner_m1: assert property (@(posedge HCLK) disable iff (HRESET)
    !(pend_m1 && dp_valid && dp_owner == M1));

endmodule

// File: tb/tb_ahb_master_arbiter.sv
module tb_ahb_master_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1;
  logic [1:0]  HTRANS_M0, HTRANS_M1;
  logic        HWRITE_M0, HWRITE_M1;
  logic [2:0]  HSIZE_M0, HSIZE_M1;
  logic        HREADY_M0, HREADY_M1;
  logic [31:0] HRDATA_M0, HRDATA_M1;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE;

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.AW(32), .DW(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
    .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1),
    .HREADY_M0(HREADY_M0), .HREADY_M1(HREADY_M1),
    .HRDATA_M0(HRDATA_M0), .HRDATA_M1(HRDATA_M1),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
  } txn_t;

  txn_t m_cap0[$];
  txn_t m_cap1[$];
  bit   m_dpv  = 1'b0;
  bit   m_own  = 1'b0;
  bit   m_last = 1'b1;

  bit   a_rst = 1'b1;
  bit   a_pop0, a_pop1, a_push0, a_push1, a_dpv, a_own, a_last;
  txn_t a_t0, a_t1;

  always @(negedge HCLK) begin : compare
    txn_t l0, l1, t;
    bit   w0, w1, w, iss;
    logic er0, er1;
    l0 = {HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0};
    l1 = {HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1};
    w0 = (m_cap0.size() != 0) || HTRANS_M0[1];
    w1 = (m_cap1.size() != 0) || HTRANS_M1[1];
`ifdef ARB_ROUND_ROBIN_EN
    if (w0 && w1)  w = ~m_last;
    else if (w0)   w = 1'b0;
    else if (w1)   w = 1'b1;
    else           w = m_last;
`else
    w = !w0 && w1;
`endif
    if (w0 || w1) begin
      if (w) t = (m_cap1.size() != 0) ? m_cap1[0] : l1;
      else   t = (m_cap0.size() != 0) ? m_cap0[0] : l0;
      chk("bus_haddr", HADDR, t.addr);
      chk("bus_htrans", {30'd0, HTRANS}, {30'd0, t.trans});
      chk("bus_hwrite", {31'd0, HWRITE}, {31'd0, t.write});
      chk("bus_hsize", {29'd0, HSIZE}, {29'd0, t.size});
    end else begin
      chk("bus_idle", {30'd0, HTRANS}, 32'd0);
    end
    er0 = (m_dpv && !m_own) ? HREADY : (m_cap0.size() == 0);
    er1 = (m_dpv &&  m_own) ? HREADY : (m_cap1.size() == 0);
    chk("hready_m0", {31'd0, HREADY_M0}, {31'd0, er0});
    chk("hready_m1", {31'd0, HREADY_M1}, {31'd0, er1});
    if (m_dpv) chk("hwdata", HWDATA, m_own ? HWDATA_M1 : HWDATA_M0);
    chk("hrdata_m0", HRDATA_M0, HRDATA);
    chk("hrdata_m1", HRDATA_M1, HRDATA);

    iss     = HREADY && (w0 || w1);
    a_rst   = HRESET;
    a_dpv   = HREADY ? iss : m_dpv;
    a_own   = HREADY ? w : m_own;
    a_last  = iss ? w : m_last;
    a_pop0  = iss && !w && (m_cap0.size() != 0);
    a_pop1  = iss &&  w && (m_cap1.size() != 0);
    a_push0 = er0 && HTRANS_M0[1] && !(iss && !w && (m_cap0.size() == 0));
    a_push1 = er1 && HTRANS_M1[1] && !(iss &&  w && (m_cap1.size() == 0));
    a_t0    = l0;
    a_t1    = l1;
  end

  always @(posedge HCLK) begin : model_step
    if (a_rst) begin
      m_cap0.delete();
      m_cap1.delete();
      m_dpv  = 1'b0;
      m_own  = 1'b0;
      m_last = 1'b1;
    end else begin
      if (a_pop0) void'(m_cap0.pop_front());
      if (a_pop1) void'(m_cap1.pop_front());
      if (a_push0) m_cap0.push_back(a_t0);
      if (a_push1) m_cap1.push_back(a_t1);
      m_dpv  = a_dpv;
      m_own  = a_own;
      m_last = a_last;
    end
  end

  // ---------------- issue log and end-to-end scoreboard ----------------
  bit          issue_log[$];
  logic [31:0] acc0[$];
  logic [31:0] acc1[$];
  bit          sb_en = 1'b0;

  always @(negedge HCLK) begin : monitor
    if (HREADY && HTRANS[1] && !HRESET) issue_log.push_back(HADDR[31]);
    if (sb_en) begin
      if (HRESET) begin
        acc0.delete();
        acc1.delete();
      end else begin
        if (HREADY_M0 && HTRANS_M0[1]) acc0.push_back(HADDR_M0);
        if (HREADY_M1 && HTRANS_M1[1]) acc1.push_back(HADDR_M1);
        if (HREADY && HTRANS[1]) begin
          if (HADDR[31]) begin
            if (acc1.size() == 0) chk("sb_m1_spurious", HADDR, 32'd0);
            else chk("sb_m1_order", HADDR, acc1.pop_front());
          end else begin
            if (acc0.size() == 0) chk("sb_m0_spurious", HADDR, 32'd0);
            else chk("sb_m0_order", HADDR, acc0.pop_front());
          end
        end
      end
    end
  end

  // ---------------- random master/slave agent ----------------
  bit auto_en = 1'b0;
  bit rst_en  = 1'b0;
  int req_pct[2];
  int rdy_pct;

  task automatic new_txn(input bit x);
    logic [31:0] a;
    logic [1:0]  tr;
    a = {x, 29'($urandom), 2'b00};
    if ($urandom_range(99) < req_pct[x]) tr = ($urandom_range(3) == 0) ? 2'b11 : 2'b10;
    else tr = 2'($urandom_range(1));
    if (x) begin
      HADDR_M1 = a; HTRANS_M1 = tr; HWRITE_M1 = 1'($urandom_range(1));
      HSIZE_M1 = 3'($urandom_range(2)); HWDATA_M1 = $urandom;
    end else begin
      HADDR_M0 = a; HTRANS_M0 = tr; HWRITE_M0 = 1'($urandom_range(1));
      HSIZE_M0 = 3'($urandom_range(2)); HWDATA_M0 = $urandom;
    end
  endtask

  initial begin : agent
    logic r0, r1;
    forever begin
      @(negedge HCLK);
      r0 = HREADY_M0;
      r1 = HREADY_M1;
      @(posedge HCLK);
      #1;
      if (auto_en) begin
        if (r0) new_txn(1'b0);
        if (r1) new_txn(1'b1);
        HREADY = ($urandom_range(99) < rdy_pct);
        HRDATA = $urandom;
        HRESET = rst_en && ($urandom_range(199) == 0);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic idle_all();
    HADDR_M0 = '0; HTRANS_M0 = 2'b00; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd2; HWDATA_M0 = '0;
    HADDR_M1 = '0; HTRANS_M1 = 2'b00; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'd2; HWDATA_M1 = '0;
    HREADY = 1'b1; HRDATA = '0;
  endtask

  task automatic do_reset();
    step();
    idle_all();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
  endtask

  initial begin : main
    int  first1;
    bit  m0_after;
    bit  exp_rr[4];
    idle_all();
    HRESET = 1'b1;
    step();
    step();
    HRESET = 1'b0;

    // reset state
    smp();
    chk("rst_hready_m0", {31'd0, HREADY_M0}, 32'd1);
    chk("rst_hready_m1", {31'd0, HREADY_M1}, 32'd1);
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);

    // solo M0 read
    step();
    HADDR_M0 = 32'h0000_1000; HTRANS_M0 = 2'b10;
    smp();
    chk("solo_haddr", HADDR, 32'h0000_1000);
    chk("solo_htrans", {30'd0, HTRANS}, 32'd2);
    chk("solo_hready_m0_a", {31'd0, HREADY_M0}, 32'd1);
    step();
    HTRANS_M0 = 2'b00; HRDATA = 32'h1234_5678;
    smp();
    chk("solo_hrdata_m0", HRDATA_M0, 32'h1234_5678);
    chk("solo_hready_m0_b", {31'd0, HREADY_M0}, 32'd1);

    // simultaneous NONSEQ
    do_reset();
    HADDR_M0 = 32'h100; HTRANS_M0 = 2'b10;
    HADDR_M1 = 32'h200; HTRANS_M1 = 2'b10;
    smp();
    chk("sim_n_haddr", HADDR, 32'h100);
    chk("sim_n_hready_m1", {31'd0, HREADY_M1}, 32'd1);
    step();
    HTRANS_M0 = 2'b00; HTRANS_M1 = 2'b00; HWDATA_M1 = 32'hA5A5_5A5A;
    smp();
    chk("sim_n1_haddr", HADDR, 32'h200);
    chk("sim_n1_htrans", {30'd0, HTRANS}, 32'd2);
    chk("sim_n1_hready_m1", {31'd0, HREADY_M1}, 32'd0);
    step();
    smp();
    chk("sim_n2_hready_m1", {31'd0, HREADY_M1}, 32'd1);
    chk("sim_n2_owner_m1", HWDATA, 32'hA5A5_5A5A);

    // write with wait states plus M0 request in the window
    do_reset();
    HADDR_M1 = 32'h300; HTRANS_M1 = 2'b10; HWRITE_M1 = 1'b1;
    smp();
    chk("ws_haddr_m1", HADDR, 32'h300);
    step();
    HTRANS_M1 = 2'b00; HWDATA_M1 = 32'hDEAD_BEEF; HREADY = 1'b0;
    HADDR_M0 = 32'h400; HTRANS_M0 = 2'b10;
    smp();
    chk("ws_hwdata_0", HWDATA, 32'hDEAD_BEEF);
    chk("ws_hready_m1_0", {31'd0, HREADY_M1}, 32'd0);
    chk("ws_hready_m0_0", {31'd0, HREADY_M0}, 32'd1);
    for (int unsigned k = 1; k < 3; k++) begin
      step();
      HTRANS_M0 = 2'b00;
      smp();
      chk("ws_hwdata_k", HWDATA, 32'hDEAD_BEEF);
      chk("ws_hready_m1_k", {31'd0, HREADY_M1}, 32'd0);
      chk("ws_hready_m0_k", {31'd0, HREADY_M0}, 32'd0);
      chk("ws_cap_haddr", HADDR, 32'h400);
      chk("ws_cap_htrans", {30'd0, HTRANS}, 32'd2);
    end
    step();
    HREADY = 1'b1;
    smp();
    chk("ws_hwdata_3", HWDATA, 32'hDEAD_BEEF);
    chk("ws_hready_m1_3", {31'd0, HREADY_M1}, 32'd1);
    chk("ws_issue_haddr", HADDR, 32'h400);
    chk("ws_hready_m0_3", {31'd0, HREADY_M0}, 32'd0);
    step();
    smp();
    chk("ws_hready_m0_4", {31'd0, HREADY_M0}, 32'd1);
    chk("ws_once_idle", {30'd0, HTRANS}, 32'd0);

    // reset with a pending M1 transfer
    do_reset();
    HADDR_M0 = 32'h100; HTRANS_M0 = 2'b10;
    HADDR_M1 = 32'h200; HTRANS_M1 = 2'b10;
    step();
    HTRANS_M0 = 2'b00; HTRANS_M1 = 2'b00; HRESET = 1'b1;
    smp();
    chk("rp_pend_hready_m1", {31'd0, HREADY_M1}, 32'd0);
    step();
    HRESET = 1'b0; HREADY = 1'b0;
    smp();
    chk("rp_hready_m1", {31'd0, HREADY_M1}, 32'd1);
    chk("rp_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rp_dp_invalid", {31'd0, HREADY_M0}, 32'd1);

    // continuous requests from both masters
    do_reset();
    issue_log.delete();
    req_pct[0] = 100; req_pct[1] = 100; rdy_pct = 100; rst_en = 1'b0;
    auto_en = 1'b1;
    repeat (6) step();
    req_pct[0] = 0;
    repeat (8) step();
    auto_en = 1'b0;
    step();
    idle_all();
    chk("cont_log_len", {31'd0, issue_log.size() >= 8}, 32'd1);
`ifdef ARB_ROUND_ROBIN_EN
    exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++)
      if (i < issue_log.size()) chk("rr_order", {31'd0, issue_log[i]}, {31'd0, exp_rr[i]});
`else
    for (int i = 0; i < 4; i++)
      if (i < issue_log.size()) chk("fixed_m0_first", {31'd0, issue_log[i]}, 32'd0);
    first1 = -1;
    m0_after = 1'b0;
    for (int i = 0; i < issue_log.size(); i++) begin
      if (issue_log[i] && first1 < 0) first1 = i;
      if (!issue_log[i] && first1 >= 0) m0_after = 1'b1;
    end
    chk("fixed_m1_late", {31'd0, first1 >= 5}, 32'd1);
    chk("fixed_no_m0_after_m1", {31'd0, m0_after}, 32'd0);
`endif

    // randomized traffic
    do_reset();
    acc0.delete();
    acc1.delete();
    sb_en = 1'b1;
    req_pct[0] = 60; req_pct[1] = 60; rdy_pct = 70; rst_en = 1'b1;
    auto_en = 1'b1;
    repeat (3000) step();
    auto_en = 1'b0;
    step();
    sb_en = 1'b0;
    idle_all();
    HRESET = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-master AHB-Lite arbiter that shares the system AHB bus (AHBlite_sys_0 slave side) between the Ibex core (M0) and a second bus master (M1, DMA/debug). It replaces the current hard-wired single-master connection (HBUSREQ/HGRANT tied high). Uncontended transfers pass through with zero added latency. A losing master's accepted address phase is held in a capture register, and that master is stalled through its own HREADY until the transfer is issued and completed.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  synchronous, active-high reset
- HADDR_M0 / HADDR_M1  in  AW  master address
- HTRANS_M0 / HTRANS_M1  in  2  master transfer type
- HWRITE_M0 / HWRITE_M1  in  1  master write
- HSIZE_M0 / HSIZE_M1  in  3  master size
- HWDATA_M0 / HWDATA_M1  in  DW  master write data
- HREADY_M0 / HREADY_M1  out  1  per-master ready
- HRDATA_M0 / HRDATA_M1  out  DW  read data, broadcast copy of HRDATA
- HADDR, HTRANS, HWRITE, HSIZE  out  AW/2/1/3  bus address phase
- HWDATA  out  DW  bus write data
- HREADY  in  1  bus ready from slave mux
- HRDATA  in  DW  bus read data

## Operation
- **Per-master state:** pend_x, plus captured {HADDR, HTRANS, HWRITE, HSIZE}.
- **Bus state:** dp_valid, dp_owner, last_gnt.
- **Request:** req_x = pend_x | HTRANS_Mx[1].
- **Arbitration:** combinational, every cycle, among req_M0 and req_M1.
  - Round robin: favour the master that is not last_gnt.
  - Fixed priority: M0 wins.
  - No requester: drive HTRANS = IDLE, and gnt holds last_gnt.
- **Bus address source:** the granted master's capture register if pend_gnt = 1, else its live inputs.
- **Issue:** on any edge with HREADY = 1:
  - dp_valid <= HTRANS[1]; dp_owner <= gnt.
  - If HTRANS[1] = 1: last_gnt <= gnt, and pend_gnt clears if the issue came from the capture register.
- **Accept:** on any edge with HREADY_Mx = 1 and HTRANS_Mx[1] = 1, master x considers its transfer accepted.
  - If it was not issued at that same edge (not granted, or bus HREADY = 0), set pend_x = 1 and capture its address phase.
- **HREADY_Mx:**
  - HREADY, when dp_valid and dp_owner = x.
  - Else ~pend_x.
- **Data path:**
  - HWDATA = HWDATA of dp_owner. Masters hold HWDATA while their HREADY is low.
  - HRDATA fans out to both masters unmodified.
- **Invariants (assertion targets):**
  - pend_x is never set while dp_owner = x and dp_valid.
  - At most one captured transfer per master.
- **Wait states:** the bus address may change while HREADY = 0, because slaves sample the address phase only on HREADY = 1. Re-arbitration happens every cycle.
- **Scope:** HBURST and HMASTLOCK are not supported; all transfers are treated as SINGLE.

## Timing
- **Reset values:** pend_M0 = pend_M1 = 0, dp_valid = 0, dp_owner = M0, last_gnt = M1, so M0 wins the first round-robin tie.
  - Resulting outputs: HREADY_M0 = HREADY_M1 = 1; HTRANS = IDLE when no live request.
- **Uncontended latency:** 0 cycles; the address appears on the bus in the same cycle.
- **Losing master:** 1 stall cycle minimum per lost arbitration, plus the other master's wait states.
- **Simultaneous NONSEQ:** the winner is issued; the loser is captured and issued at the next HREADY = 1 edge. Under round robin, the loser has priority at that edge.
- **Reset mid-operation:** HRESET wins over issue and accept in the same cycle. Captured transfers are dropped, with no error response.

## Configuration
- **ARB_ROUND_ROBIN_EN defined:** round-robin arbitration via last_gnt.
- **Not defined:** fixed priority, M0 highest. M1 can starve while M0 issues back-to-back, and last_gnt is not implemented.

## Structure
- **Shared package/header ahb_pkg:** HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), master index constants M0 and M1, AW/DW defaults.
- **Sub-module ahb_addr_capture:** instantiated once per master. Holds pend_x and the captured address phase, provides load/clear controls, and outputs the muxed address-phase source.

## Test plan
- **Solo M0 read:** M0 NONSEQ read of 0x0000_1000, HREADY = 1, HRDATA = 0x1234_5678 → bus HADDR = 0x1000 in the same cycle; HRDATA_M0 = 0x1234_5678 next cycle; HREADY_M0 never low.
- **Simultaneous NONSEQ:** M0 to 0x100, M1 to 0x200, both in cycle n →
  - Bus: 0x100 in n, 0x200 (from capture) in n+1.
  - HREADY_M1: 0 in n+1, 1 in n+2.
  - dp_owner: M1 in n+2.
- **Continuous requests, macro defined:** both masters request every cycle → issue order M0, M1, M0, M1.
- **Continuous requests, macro undefined:** same stimulus → M0 every cycle; M1 issued only after M0 goes IDLE.
- **Write with wait states:** M1 write, HWDATA_M1 = 0xDEAD_BEEF, slave holds HREADY = 0 for 3 cycles →
  - Bus HWDATA = 0xDEAD_BEEF throughout; HREADY_M1 low for 3 cycles.
  - A new M0 request in that window is captured once and issued on the first HREADY = 1 edge.
- **Reset with pending transfer:** HRESET asserted for 1 cycle while pend_M1 = 1 → next cycle HREADY_M1 = 1, HTRANS = IDLE, dp_valid = 0.
